// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR program-memory fetch path:
// READ opcode, phase bit counts and the fetch FSM encoding.
package spi_flash_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int DATA_BITS = 8;
  localparam int NBITS_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CS_SETUP   = 3'd1,
    ST_SHIFT_CMD  = 3'd2,
    ST_SHIFT_ADDR = 3'd3,
    ST_SHIFT_DATA = 3'd4,
    ST_DESELECT   = 3'd5
  } fetch_state_e;

  // 24-bit flash address for a core byte address; carry out is dropped.
  function automatic logic [23:0] flash_byte_addr(input logic [23:0] base,
                                                  input logic [11:0] core_addr);
    return base + {12'h000, core_addr};
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: SCLK divider, MSB-first shift-out and shift-in.
// A start in the cycle done is high chains the next group with no gap.
module spi_bit_engine
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [NBITS_W-1:0] nbits_i,
  input  logic [23:0]        tx_i,
  input  logic               miso_i,
  output logic               sclk_o,
  output logic               mosi_o,
  output logic               bit_end_o,
  output logic               done_o,
  output logic [7:0]         rx_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic               busy_q, busy_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [NBITS_W-1:0] left_q, left_d;
  logic [23:0]        sh_q, sh_d;
  logic [7:0]         rx_q, rx_d;
  logic               div_last;

  assign div_last  = (div_q == DIV_LAST);
  assign bit_end_o = busy_q && sclk_q && div_last;
  assign done_o    = bit_end_o && (left_q == NBITS_W'(1));
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign rx_o      = rx_q;

  always_comb begin
    busy_d = busy_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    div_d  = div_q;
    left_d = left_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    if (abort_i) begin
      busy_d = 1'b0;
      sclk_d = 1'b0;
      mosi_d = 1'b0;
      div_d  = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      sclk_d = 1'b0;
      div_d  = '0;
      left_d = nbits_i;
      mosi_d = tx_i[23];
      sh_d   = {tx_i[22:0], 1'b0};
    end else if (busy_q) begin
      if (!div_last) begin
        div_d = div_q + DIV_W'(1);
      end else begin
        div_d = '0;
        if (!sclk_q) begin
          // MISO is taken on the clk edge that raises SCLK
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], miso_i};
        end else begin
          sclk_d = 1'b0;
          if (left_q == NBITS_W'(1)) begin
            busy_d = 1'b0;
          end else begin
            left_d = left_q - NBITS_W'(1);
            mosi_d = sh_q[23];
            sh_d   = {sh_q[22:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      div_q  <= '0;
      left_q <= '0;
      sh_q   <= '0;
      rx_q   <= '0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      div_q  <= div_d;
      left_q <= left_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
    end
  end

endmodule

// File: rtl/spi_flash_fetch.sv
// Program-memory fetch from SPI NOR (READ 0x03, mode 0). Sequential core
// addresses are streamed on an open chip select; anything else re-addresses.
module spi_flash_fetch
  import spi_flash_pkg::*;
#(
  parameter int          CLK_DIV    = 2,
  parameter logic [23:0] BASE_ADDR  = 24'h000000,
  parameter int          CSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [11:0] flash_addr,
  output logic [7:0]  flash_data,
  output logic        flash_ready,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int CSH_W = (CSH_CYCLES > 1) ? $clog2(CSH_CYCLES) : 1;
  localparam logic [CSH_W-1:0] CSH_LAST = CSH_W'(CSH_CYCLES - 1);

  fetch_state_e       state_q, state_d;
  logic [11:0]        target_q, target_d;
  logic [11:0]        held_addr_q, held_addr_d;
  logic               held_valid_q, held_valid_d;
  logic               streaming_q, streaming_d;
  logic               abort_pend_q, abort_pend_d;
  logic [CSH_W-1:0]   csh_q, csh_d;
  logic               cs_n_q, cs_n_d;
  logic               ready_q, ready_d;
  logic [7:0]         data_q, data_d;

  logic               eng_start, eng_abort, eng_bit_end, eng_done;
  logic [NBITS_W-1:0] eng_nbits;
  logic [23:0]        eng_tx;
  logic [7:0]         eng_rx;

  logic               mismatch, seq_hit, abort_now;
  logic [23:0]        addr_tx;

  assign mismatch  = !held_valid_q || (flash_addr != held_addr_q);
  // 0xFFF -> 0x000 is not sequential: the flash would continue past the window
  assign seq_hit   = streaming_q && (held_addr_q != 12'hFFF) &&
                     (flash_addr == held_addr_q + 12'd1);
  assign abort_now = abort_pend_q || (flash_addr != target_q);
  assign addr_tx   = flash_byte_addr(BASE_ADDR, target_q);

  spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk       (clk),
    .arst_n    (arst_n),
    .start_i   (eng_start),
    .abort_i   (eng_abort),
    .nbits_i   (eng_nbits),
    .tx_i      (eng_tx),
    .miso_i    (spi_miso),
    .sclk_o    (spi_sclk),
    .mosi_o    (spi_mosi),
    .bit_end_o (eng_bit_end),
    .done_o    (eng_done),
    .rx_o      (eng_rx)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      held_addr_q  <= '0;
      held_valid_q <= 1'b0;
      streaming_q  <= 1'b0;
      abort_pend_q <= 1'b0;
      csh_q        <= '0;
      cs_n_q       <= 1'b1;
      ready_q      <= 1'b0;
      data_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      held_addr_q  <= held_addr_d;
      held_valid_q <= held_valid_d;
      streaming_q  <= streaming_d;
      abort_pend_q <= abort_pend_d;
      csh_q        <= csh_d;
      cs_n_q       <= cs_n_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    held_addr_d  = held_addr_q;
    held_valid_d = held_valid_q;
    streaming_d  = streaming_q;
    abort_pend_d = abort_pend_q;
    csh_d        = csh_q;
    data_d       = data_q;
    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (mismatch) begin
          if (seq_hit) begin
            state_d  = ST_SHIFT_DATA;
            target_d = flash_addr;
          end else if (!cs_n_q) begin
            state_d     = ST_DESELECT;
            streaming_d = 1'b0;
            csh_d       = '0;
          end else begin
            state_d  = ST_CS_SETUP;
            target_d = flash_addr;
          end
        end
      end
      ST_DESELECT: begin
        if (csh_q == CSH_LAST) begin
          state_d  = ST_CS_SETUP;
          target_d = flash_addr;
        end else begin
          csh_d = csh_q + CSH_W'(1);
        end
      end
      ST_CS_SETUP, ST_SHIFT_CMD, ST_SHIFT_ADDR, ST_SHIFT_DATA: begin
        // A moved address is remembered and acted on at the next bit boundary
        abort_pend_d = abort_now;
        if (eng_bit_end && abort_now) begin
          state_d      = ST_DESELECT;
          held_valid_d = 1'b0;
          streaming_d  = 1'b0;
          abort_pend_d = 1'b0;
          csh_d        = '0;
        end else if (state_q == ST_CS_SETUP) begin
          state_d = ST_SHIFT_CMD;
        end else if (eng_done) begin
          if (state_q == ST_SHIFT_CMD) begin
            state_d = ST_SHIFT_ADDR;
          end else if (state_q == ST_SHIFT_ADDR) begin
            state_d = ST_SHIFT_DATA;
          end else begin
            state_d      = ST_IDLE;
            data_d       = eng_rx;
            held_addr_d  = target_q;
            held_valid_d = 1'b1;
            streaming_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eng_start = 1'b0;
    eng_abort = 1'b0;
    eng_nbits = '0;
    eng_tx    = '0;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_SHIFT_DATA) begin
          eng_start = 1'b1;
          eng_nbits = NBITS_W'(DATA_BITS);
        end
      end
      ST_CS_SETUP: begin
        eng_start = 1'b1;
        eng_nbits = NBITS_W'(CMD_BITS);
        eng_tx    = {SPI_CMD_READ, 16'h0000};
      end
      ST_SHIFT_CMD: begin
        if (state_d == ST_SHIFT_ADDR) begin
          eng_start = 1'b1;
          eng_nbits = NBITS_W'(ADDR_BITS);
          eng_tx    = addr_tx;
        end
      end
      ST_SHIFT_ADDR: begin
        if (state_d == ST_SHIFT_DATA) begin
          eng_start = 1'b1;
          eng_nbits = NBITS_W'(DATA_BITS);
        end
      end
      default: ;
    endcase
    if ((state_q != ST_IDLE) && (state_q != ST_DESELECT) && (state_d == ST_DESELECT))
      eng_abort = 1'b1;
    cs_n_d  = (state_d == ST_DESELECT) || ((state_d == ST_IDLE) && !streaming_d);
    ready_d = held_valid_q && (flash_addr == held_addr_q);
  end

  assign flash_data  = data_q;
  assign flash_ready = ready_q;
  assign spi_cs_n    = cs_n_q;

endmodule
